// File: rtl/reg_fifo.sv
// -----------------------------------------------------------------------------
// reg_fifo
//   Synchronous FIFO that sits directly upstream of the 32-bit register stage.
//   It absorbs bursts from the producer and hands words out one per accepted
//   read, on a registered output that drives the register's data input.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset; clears pointers, count, O, flags
//   I      : write data (N bits)
//   wr_en  : write request; accepted only when not full
//   rd_en  : read request; accepted only when not empty
//   O      : registered read data; valid one cycle after the accepting edge,
//            holds its value between reads
//   full   : count == DEPTH (decoded combinationally from count)
//   empty  : count == 0     (decoded combinationally from count)
//   count  : stored words, 0..DEPTH
//   ovf    : sticky, set by a write attempted while full
//   unf    : sticky, set by a read attempted while empty
// -----------------------------------------------------------------------------
module reg_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  I,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [N-1:0]  O,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          unf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [N-1:0]  r_o;
    logic          r_ovf;
    logic          r_unf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Status comes straight from the registered count so that the accept
    // decisions below see the state as it was before the edge; a full FIFO
    // cannot reuse the slot freed by a same-cycle read.
    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    // Storage has no reset: its contents are meaningless until written and
    // the pointers/count fully describe which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= I;
        end
    end

    // Pointers wrap naturally because they are exactly AW bits wide and
    // DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
        end
    end

    // Count moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + (AW+1)'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - (AW+1)'(1);
        end
    end

    // Output register: reads from the old rptr entry, so a write into an
    // empty FIFO is never forwarded to O in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_o <= '0;
        end else if (w_rd_acc) begin
            r_o <= r_mem[r_rptr];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_ovf <= 1'b1;
            if (rd_en && w_empty) r_unf <= 1'b1;
        end
    end

    assign O     = r_o;
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_reg_fifo.sv
module tb_reg_fifo;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  I;
    logic          wr_en;
    logic          rd_en;
    logic [N-1:0]  O;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          unf;

    reg_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .I(I), .wr_en(wr_en), .rd_en(rd_en),
        .O(O), .full(full), .empty(empty), .count(count), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the expected output and flags.
    logic [N-1:0] mq [$];
    logic [N-1:0] m_o;
    logic         m_ovf;
    logic         m_unf;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".O"},     64'(O),     64'(m_o));
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".full"},  64'(full),  64'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
        chk({tag, ".ovf"},   64'(ovf),   64'(m_ovf));
        chk({tag, ".unf"},   64'(unf),   64'(m_unf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_o   = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, check #1 later.
    task automatic step(input string tag, input logic w, input logic r, input logic [N-1:0] d);
        bit was_full, was_empty;
        wr_en = w;
        rd_en = r;
        I     = d;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (r && !was_empty) m_o = mq.pop_front();
        if (w && !was_full)  mq.push_back(d);
        if (w && was_full)   m_ovf = 1'b1;
        if (r && was_empty)  m_unf = 1'b1;
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [N-1:0] t2 [4];
        t2[0] = 21512; t2[1] = 2352521; t2[2] = 3251255; t2[3] = 2254;
        wr_en = 0; rd_en = 0; I = '0;
        model_reset();

        // 1: reset then idle
        reset = 1'b0;
        #7;
        reset = 1'b1;
        #1;
        chk_all("reset");

        // 2: burst write then drain
        for (int k = 0; k < 4; k++) step("t2_wr", 1, 0, t2[k]);
        for (int k = 0; k < 4; k++) step("t2_rd", 0, 1, '0);
        chk("t2_last_O", 64'(O), 64'(32'd2254));

        // 3: overflow while full
        for (int k = 0; k < 4; k++) step("t3_fill", 1, 0, N'(100 + k));
        step("t3_ovf", 1, 0, 234522);
        chk("t3_ovf_flag", 64'(ovf), 64'd1);
        for (int k = 0; k < 4; k++) step("t3_drain", 0, 1, '0);

        // 4: underflow, simultaneous access on empty, then read
        step("t4_unf", 0, 1, '0);
        chk("t4_unf_flag", 64'(unf), 64'd1);
        step("t4_both_empty", 1, 1, 3425692);
        step("t4_rd", 0, 1, '0);
        chk("t4_O", 64'(O), 64'(32'd3425692));

        // 5: hold count at 2 with simultaneous access across the pointer wrap
        step("t5_pre", 1, 0, 901);
        step("t5_pre", 1, 0, 902);
        for (int k = 1; k <= 6; k++) step("t5_both", 1, 1, N'(k));
        step("t5_drain", 0, 1, '0);
        step("t5_drain", 0, 1, '0);

        // simultaneous access while full: read wins, write dropped
        for (int k = 0; k < 4; k++) step("full_fill", 1, 0, N'(500 + k));
        step("full_both", 1, 1, 777);
        for (int k = 0; k < 3; k++) step("full_drain", 0, 1, '0);

        // randomized traffic
        for (int k = 0; k < 300; k++)
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));

        // 6: reset between edges with count = 3
        while (mq.size() > 0) step("t6_empty", 0, 1, '0);
        for (int k = 0; k < 3; k++) step("t6_fill", 1, 0, N'(4000 + k));
        step("t6_rd", 0, 1, '0);
        step("t6_wr", 1, 0, 4100);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("t6_async");
        #1;
        reset = 1'b1;
        step("t6_post_wr", 1, 0, 13964);
        step("t6_post_rd", 0, 1, '0);
        chk("t6_O", 64'(O), 64'(32'd13964));

        // more random traffic after reset
        for (int k = 0; k < 200; k++)
            step("rand2", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
- Synchronous first-in/first-out buffer placed directly upstream of the 32-bit register stage.
- Absorbs bursts of N-bit words from the producer and delivers them, one per read request, on a registered output that drives the register's data input.
- Provides full/empty/occupancy status and sticky error flags for illegal accesses.

Parameters:
N, 32, data word width in bits
DEPTH, 4, number of storage entries; must be a power of two, at least 2
AW, 2, address width; must equal log2(DEPTH)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
I  input  N  write data
wr_en  input  1  write request
rd_en  input  1  read request
O  output  N  registered read data, feeds the downstream register
full  output  1  1 when count == DEPTH
empty  output  1  1 when count == 0
count  output  AW+1  number of stored words, 0..DEPTH
ovf  output  1  sticky: a write was attempted while full
unf  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (reset == 0, asynchronous, independent of clk):
  - Write pointer, read pointer and count go to 0.
  - O = 0, ovf = 0, unf = 0; therefore empty = 1 and full = 0.
  - Storage array contents are don't-care.
  - Reset asserted mid-burst discards all stored words.
  - First edge after release (reset returning to 1) operates normally.
- Write accepted = wr_en & ~full:
  - mem[wptr] <= I; wptr increments modulo DEPTH.
- Read accepted = rd_en & ~empty:
  - O <= mem[rptr]; rptr increments modulo DEPTH.
  - Read latency is 1 cycle: data appears on O after the edge that accepts the read.
  - O holds its last value when no read is accepted; it never returns to 0 except on reset.
- Count update per edge:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted or neither is.
- Status outputs: full and empty are decoded combinationally from count; no extra latency.
- Simultaneous wr_en & rd_en:
  - When empty: the write is accepted, the read is rejected and unf is set. There is no write-through, so O keeps its old value.
  - When full: the read is accepted and the write is rejected; ovf is set. Full is evaluated before the edge, so there is no same-cycle slot reuse.
  - Otherwise both are accepted and count is unchanged.
- Errors:
  - wr_en while full: data is dropped, state is unchanged, ovf <= 1.
  - rd_en while empty: O is unchanged, unf <= 1.
  - ovf and unf remain set until the next reset.
- Pointer wrap: pointers are AW bits wide and wrap naturally from DEPTH-1 to 0. Word ordering must be preserved across the wrap.
- Inputs I, wr_en and rd_en are sampled only at the rising edge of clk.

Test Plan:
1. Reset then idle: reset = 0 for 7 time units, then release.
   -> O = 0, empty = 1, full = 0, count = 0, ovf = 0, unf = 0.
2. Write 21512, 2352521, 3251255, 2254 on consecutive cycles, then assert rd_en for 4 cycles.
   -> count goes 1, 2, 3, 4 and full = 1 at count 4.
   -> O goes 21512, 2352521, 3251255, 2254, each one cycle after its read edge.
   -> Ends with empty = 1 and O holding 2254.
3. Fill to 4 words, then assert wr_en with I = 234522.
   -> Word is dropped, ovf = 1, count stays 4.
   -> Draining returns the original four words only.
4. From empty, assert rd_en alone.
   -> unf = 1, O unchanged.
   -> Next cycle assert wr_en & rd_en with I = 3425692: count = 1, O unchanged.
   -> Following read gives O = 3425692.
5. Wrap and simultaneous access:
   -> Hold count at 2 with simultaneous wr_en & rd_en for 6 cycles, writing 1..6.
   -> O sequence continues in write order across the pointer wrap; count stays 2.
6. Reset mid-operation: with count = 3, pull reset low between clock edges.
   -> O = 0, count = 0, empty = 1, ovf = unf = 0 immediately, before the next edge.
   -> After release, writing 13964 then reading gives O = 13964.
